add_norm_pack: RTL and testbench

- Post-addition normalize/round stage of the SD4 MAC datapath.
- Sits directly downstream of the register stage that holds the 20-bit two's-complement signed sum and the 6-bit max exponent.
- Converts the (signed_sum, exp_max) pair into packed sign/exponent/mantissa floating-point form, with zero/overflow/underflow flags.
- Two-stage elastic pipeline with valid/ready handshake.

---
 rtl/sd4_mac_pkg.sv | 20 ++
 rtl/add_norm_lzc.sv | 24 ++
 rtl/add_norm_pack.sv | 165 ++++++++++++++++
 tb/tb_add_norm_pack.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sd4_mac_pkg.sv
// Shared widths, exponent limits and the packed floating-point result type
// for the SD4 MAC datapath.
package sd4_mac_pkg;

    localparam int SUM_W        = 20;
    localparam int EXP_W        = 6;
    localparam int MAN_W        = 10;
    localparam int EXP_BIAS     = 31;
    localparam int EXP_MAX_NORM = 62;
    localparam int EXP_INF      = 63;
    localparam int POINT_POS    = 16;
    localparam int LZ_W         = $clog2(SUM_W);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

endpackage

// File: rtl/add_norm_lzc.sv
// Combinational leading-one detector: index of the most significant set bit
// and a flag for an all-zero input.
module add_norm_lzc #(
    parameter int W     = 20,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             all_zero
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign all_zero = (vec == '0);

endmodule

// File: rtl/add_norm_pack.sv
// Two-stage normalize/round/pack of the signed sum into sign/exp/man form.
// ADD_NORM_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module add_norm_pack
    import sd4_mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] signed_sum_in,
    input  logic [EXP_W-1:0] exp_max_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] man_out,
    output logic             zero_out,
    output logic             ovf_out,
    output logic             unf_out
);

    localparam int EW = EXP_W + 2;

    // Stage 1 state
    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic             s1_zero_reg;
    logic [LZ_W-1:0]  s1_lz_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [SUM_W-1:0] s1_mag_reg;

    // Stage 2 state
    logic             s2_valid_reg;
    fp_t              s2_res_reg;
    logic             s2_zero_reg;
    logic             s2_ovf_reg;
    logic             s2_unf_reg;

    logic             s2_advance;
    logic             in_sign;
    logic [SUM_W-1:0] in_mag;
    logic [LZ_W-1:0]  in_lz;
    logic             in_zero;

    assign s2_advance = !s2_valid_reg || out_ready;
    assign in_ready   = !s1_valid_reg || s2_advance;

    assign in_sign = signed_sum_in[SUM_W-1];
    assign in_mag  = in_sign ? (~signed_sum_in + SUM_W'(1)) : signed_sum_in;

    add_norm_lzc #(.W(SUM_W), .IDX_W(LZ_W)) u_lzc (
        .vec      (in_mag),
        .idx      (in_lz),
        .all_zero (in_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_lz_reg    <= '0;
            s1_exp_reg   <= '0;
            s1_mag_reg   <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg <= in_sign;
                s1_zero_reg <= in_zero;
                s1_lz_reg   <= in_lz;
                s1_exp_reg  <= exp_max_in;
                s1_mag_reg  <= in_mag;
            end
        end
    end

    // Left-justify the magnitude so the leading one lands on the top bit.
    logic [LZ_W-1:0]        shift;
    logic [SUM_W-1:0]       norm;
    logic [MAN_W-1:0]       frac;
    logic signed [EW-1:0]   exp_raw;
    logic signed [EW-1:0]   exp_rnd;
    logic [MAN_W-1:0]       man_rnd;
    logic                   unused_norm;

    assign shift   = LZ_W'(SUM_W - 1) - s1_lz_reg;
    assign norm    = s1_mag_reg << shift;
    assign frac    = norm[SUM_W-2 -: MAN_W];
    assign exp_raw = $signed({2'b00, s1_exp_reg})
                   + $signed({{(EW-LZ_W){1'b0}}, s1_lz_reg})
                   - $signed(EW'(POINT_POS));

`ifdef ADD_NORM_RNE_EN
    logic           guard;
    logic           sticky;
    logic           round_inc;
    logic [MAN_W:0] frac_inc;

    assign guard       = norm[SUM_W-2-MAN_W];
    assign sticky      = |norm[SUM_W-3-MAN_W:0];
    assign round_inc   = guard && (sticky || frac[0]);
    assign frac_inc    = {1'b0, frac} + {{MAN_W{1'b0}}, round_inc};
    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign man_rnd     = frac_inc[MAN_W-1:0];
    assign exp_rnd     = exp_raw + $signed({{(EW-1){1'b0}}, frac_inc[MAN_W]});
    assign unused_norm = norm[SUM_W-1];
`else
    assign man_rnd     = frac;
    assign exp_rnd     = exp_raw;
    assign unused_norm = ^{norm[SUM_W-1], norm[SUM_W-2-MAN_W:0]};
`endif

    fp_t  res_next;
    logic zero_next;
    logic ovf_next;
    logic unf_next;

    always_comb begin
        res_next  = '0;
        zero_next = 1'b0;
        ovf_next  = 1'b0;
        unf_next  = 1'b0;
        if (s1_zero_reg) begin
            zero_next = 1'b1;
        end else if (exp_rnd > $signed(EW'(EXP_MAX_NORM))) begin
            res_next.sign = s1_sign_reg;
            res_next.exp  = EXP_W'(EXP_INF);
            ovf_next      = 1'b1;
        end else if (exp_rnd < $signed(EW'(1))) begin
            res_next.sign = s1_sign_reg;
            unf_next      = 1'b1;
        end else begin
            res_next.sign = s1_sign_reg;
            res_next.exp  = exp_rnd[EXP_W-1:0];
            res_next.man  = man_rnd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_res_reg   <= '0;
            s2_zero_reg  <= 1'b0;
            s2_ovf_reg   <= 1'b0;
            s2_unf_reg   <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_res_reg  <= res_next;
                s2_zero_reg <= zero_next;
                s2_ovf_reg  <= ovf_next;
                s2_unf_reg  <= unf_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign sign_out  = s2_res_reg.sign;
    assign exp_out   = s2_res_reg.exp;
    assign man_out   = s2_res_reg.man;
    assign zero_out  = s2_zero_reg;
    assign ovf_out   = s2_ovf_reg;
    assign unf_out   = s2_unf_reg;

endmodule

// File: tb/tb_add_norm_pack.sv
// Directed bench for add_norm_pack: latency, classes, rounding, backpressure, reset.
module tb_add_norm_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] signed_sum_in;
    logic [5:0]  exp_max_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [5:0]  exp_out;
    logic [9:0]  man_out;
    logic        zero_out;
    logic        ovf_out;
    logic        unf_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    add_norm_pack dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .signed_sum_in (signed_sum_in),
        .exp_max_in    (exp_max_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sign_out      (sign_out),
        .exp_out       (exp_out),
        .man_out       (man_out),
        .zero_out      (zero_out),
        .ovf_out       (ovf_out),
        .unf_out       (unf_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input logic s, input logic [5:0] e,
                             input logic [9:0] m, input logic z, input logic o, input logic u);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sign"},  32'(sign_out),  32'(s));
        check({tag, ".exp"},   32'(exp_out),   32'(e));
        check({tag, ".man"},   32'(man_out),   32'(m));
        check({tag, ".zero"},  32'(zero_out),  32'(z));
        check({tag, ".ovf"},   32'(ovf_out),   32'(o));
        check({tag, ".unf"},   32'(unf_out),   32'(u));
        $display("txn %s: sign=%0d exp=%0d man=0x%0h z=%0d o=%0d u=%0d",
                 tag, sign_out, exp_out, man_out, zero_out, ovf_out, unf_out);
    endtask

    // Called at posedge+1 with an empty pipeline and out_ready=1.
    task automatic send(input string tag, input logic [19:0] sum, input logic [5:0] em,
                        input logic s, input logic [5:0] e, input logic [9:0] m,
                        input logic z, input logic o, input logic u);
        in_valid      = 1'b1;
        signed_sum_in = sum;
        exp_max_in    = em;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_out(tag, s, e, m, z, o, u);
        @(posedge clk); #1;
        check({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        signed_sum_in = '0;
        exp_max_in    = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.fields", {21'd0, sign_out, exp_out, man_out, zero_out, ovf_out, unf_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send("pos_one",   20'h10000, 6'd31, 1'b0, 6'd31, 10'h000, 1'b0, 1'b0, 1'b0);
        send("neg_one",   20'hF0000, 6'd31, 1'b1, 6'd31, 10'h000, 1'b0, 1'b0, 1'b0);
        send("small",     20'h00001, 6'd20, 1'b0, 6'd4,  10'h000, 1'b0, 1'b0, 1'b0);
        send("underflow", 20'h00001, 6'd10, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 1'b1);
        send("mid",       20'h00C00, 6'd31, 1'b0, 6'd26, 10'h200, 1'b0, 1'b0, 1'b0);
        send("overflow",  20'h80000, 6'd60, 1'b1, 6'd63, 10'h000, 1'b0, 1'b1, 1'b0);
        send("zero",      20'h00000, 6'd31, 1'b0, 6'd0,  10'h000, 1'b1, 1'b0, 1'b0);
        send("tie_even",  20'h10020, 6'd31, 1'b0, 6'd31, 10'h000, 1'b0, 1'b0, 1'b0);
`ifdef ADD_NORM_RNE_EN
        send("rnd_carry", 20'h1FFE0, 6'd31, 1'b0, 6'd32, 10'h000, 1'b0, 1'b0, 1'b0);
        send("rnd_up",    20'h10021, 6'd31, 1'b0, 6'd31, 10'h001, 1'b0, 1'b0, 1'b0);
`else
        send("rnd_carry", 20'h1FFE0, 6'd31, 1'b0, 6'd31, 10'h3FF, 1'b0, 1'b0, 1'b0);
        send("rnd_up",    20'h10021, 6'd31, 1'b0, 6'd31, 10'h000, 1'b0, 1'b0, 1'b0);
`endif

        // Backpressure: three back-to-back inputs with the sink stalled.
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        signed_sum_in = 20'h10000;
        exp_max_in    = 6'd31;
        #1;
        check("bp.ready_a", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        signed_sum_in = 20'h20000;
        check("bp.ready_b", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        signed_sum_in = 20'h30000;
        check("bp.ready_c", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp.hold_ready", 32'(in_ready), 32'd0);
        check_out("bp.hold_a", 1'b0, 6'd31, 10'h000, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_out("bp.out_b", 1'b0, 6'd32, 10'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_out("bp.out_c", 1'b0, 6'd32, 10'h200, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("bp.no_dup", 32'(out_valid), 32'd0);

        // Reset with two entries in flight.
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        signed_sum_in = 20'h10000;
        @(posedge clk); @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mid.pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check("rst_mid.exp", 32'(exp_out), 32'd0);
        check("rst_mid.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_mid.discarded", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
